// File: rtl/i2s_audio_rx.sv
// I2S receiver: oversamples SCK/WS/SD on clk and emits one channel's 16-bit
// samples as single-cycle pulses, flagging selected slots that end early.
module i2s_audio_rx #(
  parameter bit CHANNEL       = 1'b0,
  parameter int MAX_SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        i2s_sck,
  input  logic        i2s_ws,
  input  logic        i2s_sd,
  output logic [15:0] audio_out,
  output logic        audio_valid,
  output logic        frame_err
);

  localparam int             CNT_W     = $clog2(MAX_SLOT_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_SLOT_BITS);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(15);

  typedef enum logic [1:0] {ST_DISABLED, ST_SYNC, ST_SHIFT, ST_SKIP} state_e;

  logic [2:0]       sck_sync_q;
  logic [1:0]       ws_sync_q, sd_sync_q;
  state_e           state_q, state_d;
  logic             ws_prev_q, ws_prev_d;
  logic             ws_seen_q, ws_seen_d;
  logic             slot_ch_q, slot_ch_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [15:0]      shift_q, shift_d;
  logic [15:0]      audio_out_q, audio_out_d;
  logic             audio_valid_q, audio_valid_d;
  logic             frame_err_q, frame_err_d;

  logic             sck_rise, ws_s, sd_s, ws_chg;
  logic [CNT_W-1:0] bit_cnt_inc;
  state_e           slot_state;

  assign sck_rise    = sck_sync_q[1] & ~sck_sync_q[2];
  assign ws_s        = ws_sync_q[1];
  assign sd_s        = sd_sync_q[1];
  // ws_seen gates out a false boundary on the very first edge after reset
  assign ws_chg      = sck_rise & ws_seen_q & (ws_s != ws_prev_q);
  assign bit_cnt_inc = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
  assign slot_state  = (ws_s == CHANNEL) ? ST_SHIFT : ST_SKIP;

  always_comb begin
    state_d       = state_q;
    ws_prev_d     = ws_prev_q;
    ws_seen_d     = ws_seen_q;
    slot_ch_d     = slot_ch_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    audio_out_d   = audio_out_q;
    audio_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    // WS history is tracked even while disabled so enabling never sees a stale level
    if (sck_rise) begin
      ws_prev_d = ws_s;
      ws_seen_d = 1'b1;
    end

    if (!enable) begin
      state_d   = ST_DISABLED;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_DISABLED: state_d = ST_SYNC;
        ST_SYNC: begin
          if (ws_chg) begin
            slot_ch_d = ws_s;
            bit_cnt_d = '0;
            state_d   = slot_state;
          end
        end
        ST_SHIFT: begin
          if (ws_chg) begin
            frame_err_d = 1'b1;
            slot_ch_d   = ws_s;
            bit_cnt_d   = '0;
            state_d     = slot_state;
          end else if (sck_rise) begin
            shift_d   = {shift_q[14:0], sd_s};
            bit_cnt_d = bit_cnt_inc;
            if (bit_cnt_q == WORD_LAST) begin
              audio_out_d   = {shift_q[14:0], sd_s};
              audio_valid_d = 1'b1;
              state_d       = ST_SKIP;
            end
          end
        end
        ST_SKIP: begin
          if (ws_chg) begin
            slot_ch_d = ws_s;
            bit_cnt_d = '0;
            state_d   = slot_state;
          end else if (sck_rise) begin
            bit_cnt_d = bit_cnt_inc;
          end
        end
        default: state_d = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q    <= '0;
      ws_sync_q     <= '0;
      sd_sync_q     <= '0;
      state_q       <= ST_DISABLED;
      ws_prev_q     <= 1'b0;
      ws_seen_q     <= 1'b0;
      slot_ch_q     <= 1'b0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      audio_out_q   <= '0;
      audio_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      sck_sync_q    <= {sck_sync_q[1:0], i2s_sck};
      ws_sync_q     <= {ws_sync_q[0], i2s_ws};
      sd_sync_q     <= {sd_sync_q[0], i2s_sd};
      state_q       <= state_d;
      ws_prev_q     <= ws_prev_d;
      ws_seen_q     <= ws_seen_d;
      slot_ch_q     <= slot_ch_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      audio_out_q   <= audio_out_d;
      audio_valid_q <= audio_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign audio_out   = audio_out_q;
  assign audio_valid = audio_valid_q;
  assign frame_err   = frame_err_q;

endmodule
